// File: rtl/mem_loader.sv
// mem_loader: loads a stream of 32-bit little-endian words into memory.
// The first byte accepted after start is the word count N; each
// following group of four bytes becomes one word written at
// BASE_ADDR, BASE_ADDR+1, ...  A write above LAST_ADDR is refused,
// flags error and ends the load (8'hFF is LED I/O and never written).
//
// Build option: define MEM_LOADER_VERIFY_EN to read back every word
// in a VERIFY cycle after its write; a mismatch sets error (sticky).
//
// Ports
//   clk            single clock, rising edge
//   reset          synchronous, active-high
//   start          one-cycle pulse, honoured only when idle
//   in_byte/in_valid/in_ready   byte stream (valid/ready handshake)
//   write_address/write_data/write_enable   memory write port
//   read_address/read_data      combinational memory read port
//   busy, done, error, words_written        status
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// COUNT | accepting the word-count byte
// BYTES | accepting the four bytes of the current word
// WRITE | one-cycle write pulse (or overflow abort)
// VERIFY| read-back compare of the word just written
// DONE  | one-cycle done pulse, then IDLE

module mem_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter logic [7:0] LAST_ADDR = 8'hFE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  write_address,
    output logic [31:0] write_data,
    output logic        write_enable,
    output logic [7:0]  read_address,
    input  logic [31:0] read_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [8:0]  words_written
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COUNT  = 3'd1,
        BYTES  = 3'd2,
        WRITE  = 3'd3,
        VERIFY = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    // One bit wider than the memory address so it can never wrap.
    logic [8:0]  addr_q, addr_d;
    logic [7:0]  remaining_q, remaining_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] word_q, word_d;
    logic        error_q, error_d;
    logic [8:0]  words_written_q, words_written_d;

    logic        accepting;
    logic        handshake;
    logic        overflow;

    assign accepting = (state_q == COUNT) || (state_q == BYTES);
    assign handshake = accepting && in_valid;
    assign overflow  = (addr_q > {1'b0, LAST_ADDR});

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        byte_idx_d      = byte_idx_q;
        word_d          = word_q;
        error_d         = error_q;
        words_written_d = words_written_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d         = COUNT;
                    error_d         = 1'b0;
                    words_written_d = 9'd0;
                    addr_d          = {1'b0, BASE_ADDR};
                end
            end
            COUNT: begin
                if (handshake) begin
                    remaining_d = in_byte;
                    byte_idx_d  = 2'd0;
                    state_d     = (in_byte == 8'd0) ? DONE : BYTES;
                end
            end
            BYTES: begin
                if (handshake) begin
                    case (byte_idx_q)
                        2'd0:    word_d[7:0]   = in_byte;
                        2'd1:    word_d[15:8]  = in_byte;
                        2'd2:    word_d[23:16] = in_byte;
                        default: word_d[31:24] = in_byte;
                    endcase
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (overflow) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    words_written_d = words_written_q + 9'd1;
                    remaining_d     = remaining_q - 8'd1;
`ifdef MEM_LOADER_VERIFY_EN
                    state_d = VERIFY;
`else
                    // remaining_q still holds the pre-decrement count here.
                    if (remaining_q == 8'd1) begin
                        state_d = DONE;
                    end else begin
                        addr_d     = addr_q + 9'd1;
                        byte_idx_d = 2'd0;
                        state_d    = BYTES;
                    end
`endif
                end
            end
            VERIFY: begin
`ifdef MEM_LOADER_VERIFY_EN
                if (read_data != word_q) begin
                    error_d = 1'b1;
                end
                if (remaining_q == 8'd0) begin
                    state_d = DONE;
                end else begin
                    addr_d     = addr_q + 9'd1;
                    byte_idx_d = 2'd0;
                    state_d    = BYTES;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= 9'd0;
            remaining_q     <= 8'd0;
            byte_idx_q      <= 2'd0;
            word_q          <= 32'd0;
            error_q         <= 1'b0;
            words_written_q <= 9'd0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            byte_idx_q      <= byte_idx_d;
            word_q          <= word_d;
            error_q         <= error_d;
            words_written_q <= words_written_d;
        end
    end

    // Handshake and write strobes are masked by reset so that no byte is
    // taken and no write lands on a cycle where reset is asserted.
    assign in_ready      = accepting && !reset;
    assign write_enable  = (state_q == WRITE) && !overflow && !reset;
    assign write_address = write_enable ? addr_q[7:0] : 8'd0;
    assign write_data    = write_enable ? word_q : 32'd0;

`ifdef MEM_LOADER_VERIFY_EN
    assign read_address = (state_q == VERIFY) ? addr_q[7:0] : 8'd0;
`else
    logic unused_read_data;
    assign unused_read_data = ^read_data;
    assign read_address     = 8'd0;
`endif

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign error         = error_q;
    assign words_written = words_written_q;

endmodule
